rs_enc_arbiter: RTL
===================

# rs_enc_arbiter

Round-robin scheduler that shares one `rs_encoder_16_8` instance between `NUM_CH` byte-stream requesters. Each requester posts a complete 8-byte message. The arbiter pulls the 8 bytes back-to-back into the encoder with `din_sop` on the first byte, then holds the encoder input idle for the 8 parity cycles. It tags each 16-byte codeword on the output with the originating channel number. It sits between the per-channel message buffers and the framing/serializer stage.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesters, 2..8.
- `CH_W`, default `$clog2(NUM_CH)`: width of the channel tag.

Ports:
- `clk`  in  1: single clock for the block and the encoder.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ch_en`  in  NUM_CH: per-channel enable mask. A masked channel is never granted. The mask is sampled at each arbitration.
- `s_req`  in  NUM_CH: channel i has all 8 message bytes available (level signal).
- `s_data`  in  NUM_CH*8: first-word-fall-through byte of channel i, in bits `[i*8 +: 8]`.
- `s_rd`  out  NUM_CH: read strobe. One-hot, high for exactly 8 consecutive cycles per grant. The byte is consumed on each cycle it is high.
- `m_val`  out  1: codeword byte valid.
- `m_sop`  out  1: first byte of the codeword.
- `m_eop`  out  1: 16th byte of the codeword.
- `m_data`  out  8: codeword byte. Bytes 1..8 are the message; bytes 9..16 are parity.
- `m_ch`  out  CH_W: channel tag, valid while `m_val` is high.
- `busy`  out  1: FSM is not in IDLE, or the tag FIFO is not empty.

## Operation
- FSM states: IDLE, DATA, PAR. A 3-bit counter `cnt` runs 0..7 in DATA and in PAR.
- **IDLE → DATA:** taken when `req_m = s_req & ch_en` is nonzero. The winner is the first set bit of `req_m` searching upward from `ptr+1`, modulo NUM_CH. On this transition the block:
  - registers the one-hot grant;
  - loads `ptr` with the winner;
  - resets `cnt` to 0.
- **DATA:** `s_rd[g]` is high for cnt 0..7.
  - Encoder `din_val = |s_rd`.
  - `din_sop = (cnt==0)`.
  - `din = s_data[g]`.
  - At cnt==7 the FSM moves to PAR.
- **PAR:** 8 cycles with `din_val` low. This is mandatory because the encoder is shifting out parity. At cnt==7:
  - if `req_m` is nonzero, arbitrate and go directly to DATA;
  - otherwise go to IDLE.
- **Request rule:** `s_req` is ignored while in DATA and PAR, except at the PAR cnt==7 decision. A requester keeps `s_req` high until its first `s_rd`. A requester that drops `s_req` before being granted is simply not selected.
- **Tag FIFO:**
  - 2 entries of CH_W bits.
  - Pushed with the winner index on the first DATA cycle.
  - Popped on `m_eop`.
  - `m_ch` is the FIFO head.
  - Push and pop in the same cycle is legal.
  - Push when full, or pop when empty, is a design error and is covered by an assertion.
- **Encoder outputs:** `m_val`/`m_sop`/`m_eop`/`m_data` are the encoder outputs passed through directly.
- **Reset mid-operation:**
  - FSM goes to IDLE, `ptr` goes to NUM_CH-1 (so channel 0 has first priority), and `s_rd` is cleared.
  - The tag FIFO is emptied and the encoder is reset.
  - A partial message is lost; requesters treat reset as a flush.

## Timing
- All outputs are 0 in reset.
- **Grant latency:** `s_req` sampled high at edge t (in IDLE) gives `s_rd` high in cycles t+1..t+8.
- **Encoder latency:** the encoder registers its output, so codeword byte k appears one cycle after input byte k. `m_sop` is at t+2, parity is in t+10..t+17, and `m_eop` is at t+17.
- **Slot length:** 16 cycles. The next `s_rd` is at t+17 at the earliest, so back-to-back codewords give `m_val` continuously high.
- **Throughput:** one codeword per 16 cycles. The grant decision takes 1 cycle from IDLE and 0 extra cycles from PAR.
- **Simultaneous requests:** resolved purely by `ptr` rotation; there is no fixed priority.
- `busy` falls one cycle after the final `m_eop` if no request is pending.

## Structure
- Package `rs_pkg` holds:
  - `RS_K=8`, `RS_N=16`;
  - the state encoding (`ST_IDLE`, `ST_DATA`, `ST_PAR`);
  - the round-robin find-first function.
- Sub-modules: one `rs_encoder_16_8` instance (`u_enc`).
- The tag FIFO and the arbiter stay inline.

## Test plan
- **Single request:** ch0 request with message 00×8 → `s_rd[0]` high for cycles 1..8; 16 output bytes all 0x00; `m_sop` at cycle 2, `m_eop` at cycle 17, `m_ch=0`.
- **Message passthrough:** ch2 sends message 01..08 → `m_data` bytes 1..8 equal 01..08; bytes 9..16 match the golden RS(16,8) model; `m_ch=2`.
- **All channels requesting continuously:** grant order 0,1,2,3,0,…; `m_val` gap-free; each `m_ch` matches its grant; codeword starts exactly 16 cycles apart.
- **Enable mask:** `ch_en=4'b1010` with all `s_req` high → only channels 1 and 3 are granted, alternating.
- **Reset mid-operation:** assert reset at DATA cnt==4 → all outputs 0 immediately; after release, ch0 wins first even if ch3 was the channel in progress.
- **Late request:** request arrives during PAR cnt==7 → `s_rd` the next cycle with no IDLE cycle; request arrives at PAR cnt==3 → also granted at PAR cnt==7, not earlier.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the RS(16,8) encoder arbiter slice.
//   RS_K / RS_N : message / codeword length in bytes
//   state_t     : arbiter FSM encoding
//   rr_pick     : round-robin find-first, searching upward from ptr+1
//   gf_mul      : GF(2^8) multiply, field polynomial x^8+x^4+x^3+x^2+1
//   gen_poly    : low 8 coefficients of the monic generator prod(x - a^i), i=0..7
package rs_pkg;

    localparam int RS_K = 8;
    localparam int RS_N = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PAR} state_t;

    // Search order ptr+1, ptr+2, ... wrapping at n; returns ptr if nothing set.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i <= n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx[2:0]]) begin
                    win   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0][7:0] gen_poly();
        logic [8:0][7:0] g;
        logic [7:0]      a;
        g    = '0;
        g[0] = 8'h01;
        a    = 8'h01;
        for (int i = 0; i < RS_N - RS_K; i++) begin
            for (int j = 8; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(a, g[j]);
            g[0] = gf_mul(a, g[0]);
            a    = gf_mul(a, 8'h02);
        end
        return g[7:0];
    endfunction

endpackage

// File: rtl/rs_encoder_16_8.sv
// Systematic RS(16,8) encoder. Message bytes pass straight through (one cycle
// registered) while feeding the parity LFSR; after the 8th byte the 8 parity
// bytes are shifted out on the following 8 cycles, regardless of din_val.
//   clk, rst_n          : clock, async active-low reset
//   din_val/din_sop/din : input byte stream, sop marks message byte 1
//   dout_val/sop/eop    : codeword byte strobe, first byte, 16th byte
//   dout                : codeword byte
module rs_encoder_16_8
    import rs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic [7:0] din,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout
);

    localparam logic [7:0][7:0] GEN = gen_poly();

    logic [7:0][7:0] lfsr, lfsr_nxt, base;
    logic [7:0]      fb;
    logic [2:0]      dcnt, pcnt;
    logic            par_act;

    // sop starts a fresh division, so the old remainder is ignored.
    always_comb begin
        base        = din_sop ? '0 : lfsr;
        fb          = din ^ base[7];
        lfsr_nxt[0] = gf_mul(fb, GEN[0]);
        for (int j = 1; j < 8; j++) lfsr_nxt[j] = base[j-1] ^ gf_mul(fb, GEN[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= '0;
            dcnt     <= 3'd0;
            pcnt     <= 3'd0;
            par_act  <= 1'b0;
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout     <= 8'h00;
        end else begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            if (par_act) begin
                dout_val <= 1'b1;
                dout     <= lfsr[7];
                lfsr     <= {lfsr[6:0], 8'h00};
                dout_eop <= (pcnt == 3'd7);
                pcnt     <= pcnt + 3'd1;
                if (pcnt == 3'd7) par_act <= 1'b0;
            end else if (din_val) begin
                dout_val <= 1'b1;
                dout_sop <= din_sop;
                dout     <= din;
                lfsr     <= lfsr_nxt;
                dcnt     <= din_sop ? 3'd1 : dcnt + 3'd1;
                // 8th message byte: remainder is complete after this edge
                if ((din_sop ? 3'd0 : dcnt) == 3'd7) begin
                    par_act <= 1'b1;
                    pcnt    <= 3'd0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_enc_arbiter.sv
// Round-robin scheduler sharing one RS(16,8) encoder among NUM_CH requesters.
// Each grant pulls 8 bytes back-to-back, then idles the encoder input for the
// 8 parity cycles; codewords are tagged with the originating channel.
//   ch_en, s_req, s_data : per-channel enable, message-ready, FWFT byte
//   s_rd                 : one-hot read strobe, 8 cycles per grant
//   m_val/m_sop/m_eop/m_data : encoder output stream
//   m_ch                 : channel tag (tag FIFO head)
//   busy                 : FSM active or tags outstanding
module rs_enc_arbiter
    import rs_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [NUM_CH-1:0]     s_req,
    input  logic [NUM_CH*8-1:0]   s_data,
    output logic [NUM_CH-1:0]     s_rd,
    output logic                  m_val,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [7:0]            m_data,
    output logic [CH_W-1:0]       m_ch,
    output logic                  busy
);

    state_t              state;
    logic [2:0]          cnt;
    logic [CH_W-1:0]     ptr;
    logic [NUM_CH-1:0]   req_m, win_oh;
    logic [CH_W-1:0]     win;
    logic                din_val, din_sop;
    logic [7:0]          din;

    assign req_m = s_req & ch_en;
    assign win   = CH_W'(rr_pick(8'(req_m), 3'(ptr), NUM_CH));

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            ptr   <= CH_W'(NUM_CH - 1);
            s_rd  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_m) begin
                        state <= ST_DATA;
                        ptr   <= win;
                        s_rd  <= win_oh;
                        cnt   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= ST_PAR;
                        s_rd  <= '0;
                    end
                end
                ST_PAR: begin
                    cnt <= cnt + 3'd1;
                    // Last parity cycle doubles as the next arbitration slot.
                    if (cnt == 3'd7) begin
                        if (|req_m) begin
                            state <= ST_DATA;
                            ptr   <= win;
                            s_rd  <= win_oh;
                            cnt   <= 3'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ptr holds the granted channel for the whole DATA phase.
    always_comb begin
        din = 8'h00;
        for (int i = 0; i < NUM_CH; i++)
            if (ptr == CH_W'(i)) din = s_data[i*8 +: 8];
    end

    assign din_val = |s_rd;
    assign din_sop = (state == ST_DATA) && (cnt == 3'd0);

    rs_encoder_16_8 u_enc (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_val  (din_val),
        .din_sop  (din_sop),
        .din      (din),
        .dout_val (m_val),
        .dout_sop (m_sop),
        .dout_eop (m_eop),
        .dout     (m_data)
    );

    // Two-entry tag FIFO: at most one codeword is in flight behind the one
    // being read, since a push and the previous pop coincide back-to-back.
    logic [1:0][CH_W-1:0] tag_mem;
    logic                 wp, rp, push, pop;
    logic [1:0]           tag_cnt;

    assign push = din_sop;
    assign pop  = m_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            tag_cnt <= 2'd0;
        end else begin
            if (push) begin
                tag_mem[wp] <= ptr;
                wp          <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 2'd1;
                2'b01:   tag_cnt <= tag_cnt - 2'd1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    assign m_ch = tag_mem[rp];
    assign busy = (state != ST_IDLE) || (tag_cnt != 2'd0);

    a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && tag_cnt == 2'd2));
    a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(pop && tag_cnt == 2'd0));

endmodule
